exc_unit: RTL and testbench

Trap/return sequencer that sits directly upstream of the `csr` block. It collects exception and `mret` requests from the execute stage and prioritises them. It then drives the one-cycle CSR exception write port (`we_exc`, `mcause_d`, `mepc_d`, `mstatus_d`, `mtval_d`, `sel_exc_nret`) and redirects fetch to the trap vector or return address. While a trap or return is in flight it stalls and flushes the pipeline.

---
 rtl/exc_unit.sv | 166 ++++++++++++++++
 tb/tb_exc_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_unit.sv
// Trap/return sequencer feeding the csr exception write port and redirecting fetch.
// Optional macro EXC_UNIT_IRQ_EN enables external interrupt traps taken in IDLE.
module exc_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] badaddr_i,
    input  logic        exc_fetch_mis_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_ecall_i,
    input  logic        exc_load_mis_i,
    input  logic        exc_store_mis_i,
    input  logic        mret_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] mtval_i,
    input  logic [31:0] mie_i,
    input  logic        irq_i,
    input  logic [31:0] exc_ret_addr_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_d_o,
    output logic [31:0] mepc_d_o,
    output logic [31:0] mstatus_d_o,
    output logic [31:0] mtval_d_o,
    output logic        sel_exc_nret_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT
    } state_t;

    state_t      state_q;
    logic [31:0] mcause_q, mepc_q, mstatus_q, mtval_q;
    logic        sel_q, we_q, flush_q, stall_q, redirect_q;

    logic        exc_any, irq_take, accept, ret_d;
    logic [31:0] mcause_d, mepc_d, mstatus_d, mtval_d;
    logic [31:0] trap_mstatus, ret_mstatus;

`ifdef EXC_UNIT_IRQ_EN
    assign irq_take = irq_i & mstatus_i[3] & mie_i[11] & valid_i;
    logic unused_mie;
    assign unused_mie = ^{mie_i[31:12], mie_i[10:0]};
`else
    assign irq_take = 1'b0;
    logic unused_irq;
    assign unused_irq = ^{irq_i, mie_i};
`endif

    assign exc_any = exc_fetch_mis_i | exc_illegal_i | exc_ebreak_i
                   | exc_ecall_i | exc_load_mis_i | exc_store_mis_i;
    assign accept  = (state_q == IDLE) && (irq_take || (valid_i && (exc_any || mret_i)));

    // NOTE: every variable gets a default before the priority chain so no latch is inferred.
    always_comb begin
        trap_mstatus        = mstatus_i;
        trap_mstatus[7]     = mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        ret_mstatus         = mstatus_i;
        ret_mstatus[3]      = mstatus_i[7];
        ret_mstatus[7]      = 1'b1;
        ret_mstatus[12:11]  = 2'b11;

        ret_d     = 1'b0;
        mepc_d    = pc_i;
        mstatus_d = trap_mstatus;
        mcause_d  = '0;
        mtval_d   = '0;
        if (irq_take) begin
            mcause_d = 32'h8000_000B;
        end else if (exc_fetch_mis_i) begin
            mcause_d = 32'd0;
            mtval_d  = badaddr_i;
        end else if (exc_illegal_i) begin
            mcause_d = 32'd2;
            mtval_d  = instr_i;
        end else if (exc_ebreak_i) begin
            mcause_d = 32'd3;
            mtval_d  = pc_i;
        end else if (exc_ecall_i) begin
            mcause_d = 32'd11;
        end else if (exc_load_mis_i) begin
            mcause_d = 32'd4;
            mtval_d  = badaddr_i;
        end else if (exc_store_mis_i) begin
            mcause_d = 32'd6;
            mtval_d  = badaddr_i;
        end else begin
            // mret: CSR state passes through except the mstatus stack pop.
            ret_d     = 1'b1;
            mepc_d    = mepc_i;
            mcause_d  = mcause_i;
            mtval_d   = mtval_i;
            mstatus_d = ret_mstatus;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mcause_q   <= '0;
            mepc_q     <= '0;
            mstatus_q  <= '0;
            mtval_q    <= '0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcause_q  <= mcause_d;
                        mepc_q    <= mepc_d;
                        mstatus_q <= mstatus_d;
                        mtval_q   <= mtval_d;
                        sel_q     <= ret_d;
                        we_q      <= 1'b1;
                        flush_q   <= 1'b1;
                        stall_q   <= 1'b1;
                        state_q   <= COMMIT;
                    end
                end
                COMMIT: begin
                    we_q       <= 1'b0;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b1;
                    state_q    <= REDIRECT;
                end
                REDIRECT: begin
                    redirect_q <= 1'b0;
                    stall_q    <= 1'b0;
                    sel_q      <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we_exc_o       = we_q;
    assign flush_o        = flush_q;
    assign redirect_o     = redirect_q;
    assign sel_exc_nret_o = sel_q;
    assign mcause_d_o     = mcause_q;
    assign mepc_d_o       = mepc_q;
    assign mstatus_d_o    = mstatus_q;
    assign mtval_d_o      = mtval_q;
    // Stall must hold the faulting instruction in the very cycle it is accepted.
    assign stall_o        = stall_q | accept;
    assign redirect_pc_o  = redirect_q ? {exc_ret_addr_i[31:2], 2'b00} : 32'h0;

endmodule

// File: tb/tb_exc_unit.sv
// Self-checking bench for exc_unit: directed cases plus random events against a reference model.
module tb_exc_unit;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, mret_i, irq_i;
    logic        exc_fetch_mis_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
    logic        exc_load_mis_i, exc_store_mis_i;
    logic [31:0] pc_i, instr_i, badaddr_i, mstatus_i, mepc_i, mcause_i, mtval_i, mie_i;
    logic [31:0] exc_ret_addr_i;
    logic        we_exc_o, sel_exc_nret_o, stall_o, flush_o, redirect_o;
    logic [31:0] mcause_d_o, mepc_d_o, mstatus_d_o, mtval_d_o, redirect_pc_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exc_unit dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
        .badaddr_i(badaddr_i), .exc_fetch_mis_i(exc_fetch_mis_i), .exc_illegal_i(exc_illegal_i),
        .exc_ebreak_i(exc_ebreak_i), .exc_ecall_i(exc_ecall_i), .exc_load_mis_i(exc_load_mis_i),
        .exc_store_mis_i(exc_store_mis_i), .mret_i(mret_i), .mstatus_i(mstatus_i),
        .mepc_i(mepc_i), .mcause_i(mcause_i), .mtval_i(mtval_i), .mie_i(mie_i), .irq_i(irq_i),
        .exc_ret_addr_i(exc_ret_addr_i), .we_exc_o(we_exc_o), .mcause_d_o(mcause_d_o),
        .mepc_d_o(mepc_d_o), .mstatus_d_o(mstatus_d_o), .mtval_d_o(mtval_d_o),
        .sel_exc_nret_o(sel_exc_nret_o), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    typedef struct {
        logic        acc;
        logic        ret;
        logic [31:0] cause;
        logic [31:0] mtval;
        logic [31:0] mepc;
        logic [31:0] ms;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // fl[0..5] = fetch, illegal, ebreak, ecall, load, store (highest priority first).
    function automatic exp_t model(input logic v, input logic [5:0] fl, input logic mr,
                                   input logic irq, input logic [31:0] pc, instr, bad,
                                   ms, mepc, mcause, mtval, mie);
        int   codes [6] = '{0, 2, 3, 11, 4, 6};
        exp_t e = '{acc: 1'b0, ret: 1'b0, cause: 32'h0, mtval: 32'h0, mepc: 32'h0, ms: 32'h0};
        logic [31:0] trap_ms = (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
        if (!v) return e;
`ifdef EXC_UNIT_IRQ_EN
        if (irq && ms[3] && mie[11]) begin
            e = '{acc: 1'b1, ret: 1'b0, cause: 32'h8000000B, mtval: 32'h0, mepc: pc, ms: trap_ms};
            return e;
        end
`endif
        for (int i = 0; i < 6; i++) begin
            if (fl[i]) begin
                e.acc   = 1'b1;
                e.cause = codes[i];
                e.mepc  = pc;
                e.ms    = trap_ms;
                case (codes[i])
                    2:       e.mtval = instr;
                    3:       e.mtval = pc;
                    11:      e.mtval = 32'h0;
                    default: e.mtval = bad;
                endcase
                return e;
            end
        end
        if (mr) begin
            e = '{acc: 1'b1, ret: 1'b1, cause: mcause, mtval: mtval, mepc: mepc,
                  ms: (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0)};
        end
        return e;
    endfunction

    task automatic drive_flags(input logic [5:0] fl);
        exc_fetch_mis_i = fl[0];
        exc_illegal_i   = fl[1];
        exc_ebreak_i    = fl[2];
        exc_ecall_i     = fl[3];
        exc_load_mis_i  = fl[4];
        exc_store_mis_i = fl[5];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".we"}, we_exc_o, 0);
        check({tag, ".stall"}, stall_o, 0);
        check({tag, ".flush"}, flush_o, 0);
        check({tag, ".redirect"}, redirect_o, 0);
        check({tag, ".sel"}, sel_exc_nret_o, 0);
        check({tag, ".rpc"}, redirect_pc_o, 0);
        check({tag, ".mcause"}, mcause_d_o, 0);
        check({tag, ".mepc"}, mepc_d_o, 0);
        check({tag, ".mstatus"}, mstatus_d_o, 0);
        check({tag, ".mtval"}, mtval_d_o, 0);
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns in the next IDLE cycle.
    task automatic run_event(input string tag, input logic v, input logic [5:0] fl,
                             input logic mr, input logic irq, input logic [31:0] pc, instr, bad,
                             ms, mepc, mcause, mtval, mie, ret_addr, input logic noise);
        exp_t e = model(v, fl, mr, irq, pc, instr, bad, ms, mepc, mcause, mtval, mie);
        valid_i = v; drive_flags(fl); mret_i = mr; irq_i = irq;
        pc_i = pc; instr_i = instr; badaddr_i = bad; mstatus_i = ms; mepc_i = mepc;
        mcause_i = mcause; mtval_i = mtval; mie_i = mie; exc_ret_addr_i = ret_addr;
        #1 check({tag, ".accept_stall"}, stall_o, e.acc);
        @(posedge clk); #1;
        if (!e.acc) begin
            check({tag, ".idle_we"}, we_exc_o, 0);
            check({tag, ".idle_redirect"}, redirect_o, 0);
            valid_i = 1'b0;
            return;
        end
        check({tag, ".c_we"}, we_exc_o, 1);
        check({tag, ".c_flush"}, flush_o, 1);
        check({tag, ".c_stall"}, stall_o, 1);
        check({tag, ".c_redirect"}, redirect_o, 0);
        check({tag, ".c_sel"}, sel_exc_nret_o, e.ret);
        check({tag, ".c_mcause"}, mcause_d_o, e.cause);
        check({tag, ".c_mepc"}, mepc_d_o, e.mepc);
        check({tag, ".c_mstatus"}, mstatus_d_o, e.ms);
        check({tag, ".c_mtval"}, mtval_d_o, e.mtval);
        if (noise) begin
            valid_i = 1'b1; drive_flags(6'b001000); mret_i = 1'b1;
        end else begin
            valid_i = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, ".r_we"}, we_exc_o, 0);
        check({tag, ".r_flush"}, flush_o, 0);
        check({tag, ".r_stall"}, stall_o, 1);
        check({tag, ".r_redirect"}, redirect_o, 1);
        check({tag, ".r_sel"}, sel_exc_nret_o, e.ret);
        check({tag, ".r_pc"}, redirect_pc_o, ret_addr & 32'hFFFF_FFFC);
        check({tag, ".r_mcause_hold"}, mcause_d_o, e.cause);
        @(posedge clk); #1;
        check({tag, ".i_we"}, we_exc_o, 0);
        check({tag, ".i_redirect"}, redirect_o, 0);
        check({tag, ".i_flush"}, flush_o, 0);
        check({tag, ".i_stall"}, stall_o, noise);
        valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0; drive_flags(6'b0);
        pc_i = 0; instr_i = 0; badaddr_i = 0; mstatus_i = 0; mepc_i = 0; mcause_i = 0;
        mtval_i = 0; mie_i = 0; exc_ret_addr_i = 0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        check_all_zero("reset");

        // ecall at 0x100, mstatus 0x8 -> mstatus_d 0x1880, redirect to 0x200
        run_event("ecall", 1, 6'b001000, 0, 0, 32'h100, 32'h73, 32'h0, 32'h8,
                  0, 0, 0, 0, 32'h200, 0);
        // illegal + load misaligned: illegal wins, single we pulse checked by r_we
        run_event("ill_ld", 1, 6'b010010, 0, 0, 32'h104, 32'hFFFF_FFFF, 32'h1001, 32'h0,
                  0, 0, 0, 0, 32'h203, 0);
        // mret from 0x1880 -> 0x1888, return to mepc 0x104
        run_event("mret", 1, 6'b0, 1, 0, 32'h108, 32'h30200073, 0, 32'h1880,
                  32'h104, 32'h11, 32'h22, 0, 32'h104, 0);
        // exception beats mret
        run_event("st_vs_mret", 1, 6'b100000, 1, 0, 32'h10C, 0, 32'hABC3, 32'h0,
                  32'h55, 0, 0, 0, 32'h300, 0);
        // no valid: flags ignored
        run_event("novalid", 0, 6'b111111, 1, 0, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // flags during COMMIT/REDIRECT ignored, then held flags accepted back-to-back
        run_event("noise", 1, 6'b000100, 0, 0, 32'h114, 0, 0, 32'h8, 0, 0, 0, 0, 32'h400, 1);
        run_event("held", 1, 6'b001000, 1, 0, 32'h118, 0, 0, 32'h8, 0, 0, 0, 0, 32'h404, 0);

        // reset during COMMIT drops the pending redirect
        valid_i = 1'b1; drive_flags(6'b001000); pc_i = 32'h500; exc_ret_addr_i = 32'h600;
        @(posedge clk); #1;
        check("rstc.we_before", we_exc_o, 1);
        rst_i = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_commit");
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("rstc.no_redirect", redirect_o, 0);
        check("rstc.no_stall", stall_o, 0);

        // irq with concurrent ecall; without the macro the ecall is taken
        run_event("irq_on", 1, 6'b001000, 0, 1, 32'h300, 0, 0, 32'h8, 0, 0, 0, 32'h800,
                  32'h700, 0);
        run_event("irq_mie0", 1, 6'b001000, 0, 1, 32'h300, 0, 0, 32'h8, 0, 0, 0, 32'h0,
                  32'h700, 0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] fl;
            fl = 6'($urandom);
            if ($urandom_range(0, 2) == 0) fl = 6'b0;
            else if ($urandom_range(0, 1) == 0) fl = fl & (6'b1 << $urandom_range(0, 5));
            run_event($sformatf("rnd%0d", n), 1'($urandom_range(0, 5) != 0), fl,
                      1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
